// File: rtl/wire_shark_pll_supervisor.sv
// Lock supervisor and reset sequencer for the Wire_Shark system PLL, clocked by refclk.
// Define WIRE_SHARK_PLL_SUP_RETRY_EN to retry the PLL reset on lock timeout instead of latching a fault.
module wire_shark_pll_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  sw_rst_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  pll_ok,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [2:0]            state
);

  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] lossCnt_q, lossCnt_d;
  logic                  lockedMeta_q, lockedSync_q;
  logic                  pllRst_q, sysRstN_q, pllOk_q;
  logic [2:0]            stateOut_q;
  logic [LOSS_CNT_W-1:0] lossOut_q;

  // locked comes from the PLL's own domain
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lockedMeta_q <= 1'b0;
      lockedSync_q <= 1'b0;
    end else begin
      lockedMeta_q <= locked;
      lockedSync_q <= lockedMeta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    lossCnt_d = lossCnt_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lockedSync_q) state_d = STABLE;
        else if (cnt_q == TIMEOUT_LAST) begin
`ifdef WIRE_SHARK_PLL_SUP_RETRY_EN
          state_d = PLL_RST;
`else
          state_d = FAULT;
`endif
        end
      end
      STABLE: begin
        if (!lockedSync_q) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lockedSync_q) begin
          state_d   = PLL_RST;
          lossCnt_d = (&lossCnt_q) ? lossCnt_q : lossCnt_q + 1'b1;
        end
      end
      FAULT: cnt_d = '0;
      default: state_d = PLL_RST;
    endcase
    if (sw_rst_req) state_d = PLL_RST;
    // a software request restarts the pulse even when already in PLL_RST
    if ((state_d != state_q) || sw_rst_req) cnt_d = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      lossCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lossCnt_q <= lossCnt_d;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pllRst_q   <= 1'b1;
      sysRstN_q  <= 1'b0;
      pllOk_q    <= 1'b0;
      stateOut_q <= 3'd0;
      lossOut_q  <= '0;
    end else begin
      pllRst_q   <= (state_q == PLL_RST) || (state_q == FAULT);
      sysRstN_q  <= (state_q == RUN);
      pllOk_q    <= (state_q == RUN);
      stateOut_q <= state_q;
      lossOut_q  <= lossCnt_q;
    end
  end

`ifdef WIRE_SHARK_PLL_SUP_RETRY_EN
  assign fault = 1'b0;
`else
  logic fault_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_q == FAULT);
  end

  assign fault = fault_q;
`endif

  assign pll_rst   = pllRst_q;
  assign sys_rst_n = sysRstN_q;
  assign pll_ok    = pllOk_q;
  assign loss_cnt  = lossOut_q;
  assign state     = stateOut_q;

endmodule

// File: tb/tb_wire_shark_pll_supervisor.sv
// Self-checking bench for wire_shark_pll_supervisor: vector table, corner sequences, randomized run vs. model.
// Follows WIRE_SHARK_PLL_SUP_RETRY_EN the same way as the design.
module tb_wire_shark_pll_supervisor;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int LW = 2;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic          pll_rst, sys_rst_n, pll_ok, fault;
  logic [LW-1:0] loss_cnt;
  logic [2:0]    state;

  int testsRun = 0;
  int failures = 0;

  wire_shark_pll_supervisor #(
    .RST_PULSE_CYCLES(RP),
    .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(LT),
    .LOSS_CNT_W(LW)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .locked(locked),
    .sw_rst_req(sw_rst_req),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .pll_ok(pll_ok),
    .fault(fault),
    .loss_cnt(loss_cnt),
    .state(state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       locked;
    logic       expPllRst;
    logic       expSysRstN;
    logic [2:0] expState;
  } vec_t;

  vec_t vecs[18];

  // reference model: phase, cycles spent in it, loss count and raw locked history
  int mPhase, mElapsed, mLoss;
  bit lockHist[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge refclk);
    #1;
  endtask

  task automatic applyStimulus(input logic lk, input logic sw);
    locked     = lk;
    sw_rst_req = sw;
  endtask

  task automatic doReset();
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_vals", {pll_rst, sys_rst_n, pll_ok, fault, 2'(loss_cnt), state},
                {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0});
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic waitState(input logic [2:0] s, input int limit, input string name);
    bit found = 0;
    for (int i = 0; i < limit; i++) begin
      stepCycle();
      if (state == s) begin
        found = 1;
        break;
      end
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic modelReset();
    lockHist.delete();
    mPhase   = 0;
    mElapsed = 0;
    mLoss    = 0;
  endtask

  // Advance the model by one edge; returns what the outputs should show after it.
  task automatic modelStep(input bit lk, input bit sw, output logic [31:0] expVec);
    int  nextPhase;
    bit  ls;
    bit  isRst, isRun, isFault;
    lockHist.push_back(lk);
    ls = (lockHist.size() >= 3) ? lockHist[lockHist.size() - 3] : 1'b0;
    isRst   = (mPhase == 0) || (mPhase == 4);
    isRun   = (mPhase == 3);
    isFault = (mPhase == 4);
    expVec  = 32'({isRst, isRun, isRun, isFault, 2'(mLoss), 3'(mPhase)});
    nextPhase = mPhase;
    case (mPhase)
      0: if (mElapsed + 1 == RP) nextPhase = 1;
      1: begin
        if (ls) nextPhase = 2;
        else if (mElapsed + 1 == LT) begin
`ifdef WIRE_SHARK_PLL_SUP_RETRY_EN
          nextPhase = 0;
`else
          nextPhase = 4;
`endif
        end
      end
      2: begin
        if (!ls) nextPhase = 1;
        else if (mElapsed + 1 == LS) nextPhase = 3;
      end
      3: if (!ls) begin
        nextPhase = 0;
        mLoss = (mLoss < 3) ? mLoss + 1 : 3;
      end
      default: ;
    endcase
    if (sw) nextPhase = 0;
    if (nextPhase != mPhase || sw) mElapsed = 0;
    else mElapsed++;
    mPhase = nextPhase;
  endtask

  initial begin
    int riseA, riseB, faultSeen, reEnter, highCnt;
    logic prevRst;
    logic [2:0] prevState;
    logic [31:0] expVec;
    bit lk;

    for (int i = 0; i < 18; i++) begin
      vecs[i].locked     = (i >= 6);
      vecs[i].expPllRst  = (i < 4);
      vecs[i].expSysRstN = (i == 17);
      vecs[i].expState   = (i < 4) ? 3'd0 : (i < 9) ? 3'd1 : (i < 17) ? 3'd2 : 3'd3;
    end

    // reset pulse length and clean lock latency from the vector table
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].locked, 1'b0);
      stepCycle();
      checkOutput($sformatf("vec%0d_pll_rst", i), 32'(pll_rst), 32'(vecs[i].expPllRst));
      checkOutput($sformatf("vec%0d_sys_rst_n", i), 32'(sys_rst_n), 32'(vecs[i].expSysRstN));
      checkOutput($sformatf("vec%0d_pll_ok", i), 32'(pll_ok), 32'(vecs[i].expSysRstN));
      checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].expState));
    end

    // four lock losses from RUN: count saturates, each re-pulses the PLL for RP cycles
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("loss_still_run", 32'(sys_rst_n), 32'd1);
      stepCycle();
      checkOutput("loss_sys_rst_n", 32'(sys_rst_n), 32'd0);
      checkOutput("loss_cnt", 32'(loss_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
      applyStimulus(1'b1, 1'b0);
      highCnt = 0;
      for (int c = 0; c < 20 && pll_rst; c++) begin
        highCnt++;
        stepCycle();
      end
      checkOutput("loss_pulse_len", 32'(highCnt), 32'(RP));
      waitState(3'd3, 40, "relock_run");
    end

    // unstable lock: a one-cycle dropout restarts the stability window
    doReset();
    waitState(3'd1, 20, "unstable_wait");
    applyStimulus(1'b1, 1'b0);
    reEnter = 0;
    prevState = state;
    for (int c = 0; c <= 17; c++) begin
      stepCycle();
      if (state == 3'd1 && prevState != 3'd1) reEnter++;
      prevState = state;
      if (c == 4) applyStimulus(1'b0, 1'b0);
      if (c == 5) applyStimulus(1'b1, 1'b0);
      if (c == 16) checkOutput("unstable_hold", 32'(sys_rst_n), 32'd0);
      if (c == 17) checkOutput("unstable_release", 32'(sys_rst_n), 32'd1);
    end
    checkOutput("unstable_reenter", 32'(reEnter), 32'd1);

    // lock timeout with locked held low
    doReset();
    for (int c = 0; c < 20 && pll_rst; c++) stepCycle();
    checkOutput("timeout_pulse_end", 32'(pll_rst), 32'd0);
`ifdef WIRE_SHARK_PLL_SUP_RETRY_EN
    riseA = -1;
    riseB = -1;
    faultSeen = 0;
    prevRst = pll_rst;
    for (int c = 1; c <= 90; c++) begin
      stepCycle();
      if (fault) faultSeen = 1;
      if (pll_rst && !prevRst) begin
        if (riseA < 0) riseA = c;
        else if (riseB < 0) riseB = c;
      end
      prevRst = pll_rst;
    end
    checkOutput("retry_first_rise", 32'(riseA), 32'(LT));
    checkOutput("retry_period", 32'(riseB - riseA), 32'(RP + LT));
    checkOutput("retry_no_fault", 32'(faultSeen), 32'd0);
`else
    for (int c = 1; c <= LT; c++) begin
      stepCycle();
      if (c == LT - 1) checkOutput("timeout_pre_fault", 32'({fault, state}), 32'({1'b0, 3'd1}));
      if (c == LT) checkOutput("timeout_fault", 32'({fault, pll_rst, state}), 32'({1'b1, 1'b1, 3'd4}));
    end
    for (int c = 0; c < 5; c++) stepCycle();
    checkOutput("fault_sticky", 32'({fault, state}), 32'({1'b1, 3'd4}));
`endif

    // software retry, then asynchronous reset in the middle of STABLE
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("sw_retry", 32'({state, fault, pll_rst, sys_rst_n}), 32'({3'd0, 1'b0, 1'b1, 1'b0}));
    waitState(3'd2, 30, "reach_stable");
    stepCycle();
    stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {pll_rst, sys_rst_n, pll_ok, fault, 2'(loss_cnt), state},
                {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0});
    stepCycle();
    rst_n = 1'b1;

    // randomized run against the model
    doReset();
    modelReset();
    lk = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) lk = ~lk;
      applyStimulus(lk, ($urandom_range(0, 199) == 0));
      @(posedge refclk);
      modelStep(locked, sw_rst_req, expVec);
      #1;
      checkOutput($sformatf("rand_c%0d", c), {pll_rst, sys_rst_n, pll_ok, fault, 2'(loss_cnt), state}, expVec);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/wire_shark_pll_supervisor.md
# wire_shark_pll_supervisor

Lock supervisor and reset sequencer on the consumer side of the Wire_Shark system PLL (100 MHz refclk in, 125 MHz outclk_0 out). Runs on the free-running 100 MHz refclk, drives the PLL's active-high reset, and watches its `locked` output. Releases the system reset only after lock has been stable for a programmed time, and counts lock losses. On lock timeout, it either retries the PLL reset or latches a fault.

## Interface
- `RST_PULSE_CYCLES`, 16: refclk cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 100000: maximum cycles in WAIT_LOCK before timeout (≥1).
- `LOSS_CNT_W`, 8: width of the lock-loss counter.

Ports:
- `refclk` in 1: 100 MHz free-running clock; the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `locked` in 1: PLL lock indicator; asynchronous to `refclk`.
- `sw_rst_req` in 1: single-cycle request to re-reset the PLL from any state.
- `pll_rst` out 1: active-high reset to the PLL `rst` pin.
- `sys_rst_n` out 1: active-low reset for downstream logic; high only in RUN.
- `pll_ok` out 1: high only in RUN.
- `fault` out 1: sticky lock-timeout fault (FAULT state only).
- `loss_cnt` out LOSS_CNT_W: saturating count of lock losses seen in RUN.
- `state` out 3: current state code.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- A single shared cycle counter `cnt` is used. Its width is clog2 of the largest cycle parameter, plus 1. It is cleared on every state transition.
- All outputs are registered and are decoded from the state register.
- State codes: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- **PLL_RST**: `pll_rst`=1.
  - When `cnt`==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - Else if `cnt`==LOCK_TIMEOUT_CYCLES-1, take the timeout action (see Configuration).
- **STABLE**: counts cycles with `locked_s`=1.
  - If `locked_s` drops, return to WAIT_LOCK. The timeout window restarts from 0.
  - When `cnt`==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
- **RUN**: `sys_rst_n`=1, `pll_ok`=1.
  - If `locked_s` falls, increment `loss_cnt` (saturating at all-ones), then go to PLL_RST.
- **FAULT**: `fault`=1, `pll_rst`=1, `sys_rst_n`=0.
  - Exit only via `rst_n` or `sw_rst_req`.
- `sw_rst_req`=1 in any state goes to PLL_RST next cycle and clears `fault`. `loss_cnt` is unchanged.
- `sw_rst_req` together with a `locked_s` fall in RUN: go to PLL_RST and increment `loss_cnt` exactly once.
- Glitches on `locked` shorter than one refclk period may be missed. This is accepted.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state=PLL_RST, `cnt`=0, `pll_rst`=1, `sys_rst_n`=0, `pll_ok`=0, `fault`=0, `loss_cnt`=0.
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYCLES cycles, then falls.
- `locked` is first sampled high at edge N, with the FSM in WAIT_LOCK. `sys_rst_n` and `pll_ok` then rise at edge N+LOCK_STABLE_CYCLES+3. Latency breakdown:
  - 2 cycles for the synchronizer.
  - 1 cycle for the WAIT_LOCK→STABLE transition.
  - LOCK_STABLE_CYCLES in STABLE.
- `locked` is sampled low in RUN at edge N:
  - `sys_rst_n` falls, `pll_rst` rises and `loss_cnt` updates at edge N+3.
- Timeout fires LOCK_TIMEOUT_CYCLES cycles after entering WAIT_LOCK.
- `sw_rst_req` at edge N gives `pll_rst`=1 and `sys_rst_n`=0 at edge N+1.

## Configuration
- `WIRE_SHARK_PLL_SUP_RETRY_EN` defined: on timeout, WAIT_LOCK→PLL_RST, and the full sequence retries indefinitely. FAULT is unreachable and `fault` is tied to 0.
- `WIRE_SHARK_PLL_SUP_RETRY_EN` undefined: on timeout, WAIT_LOCK→FAULT, which is sticky until `rst_n` or `sw_rst_req`.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, LOSS_CNT_W=2.

- **Reset and pulse**: release `rst_n` with `locked`=0 → `pll_rst`=1 for exactly 4 cycles, then 0. `state`=1, `sys_rst_n`=0.
- **Clean lock**: after the pulse, raise `locked` → `sys_rst_n`=1, `pll_ok`=1, `state`=3 exactly 11 cycles after the first high sample.
- **Unstable lock**: `locked` high 5 cycles, low 1 cycle, then high → no release until 8 consecutive synchronized-high cycles. WAIT_LOCK re-entered once.
- **Loss and saturation**: from RUN, drop `locked` 4 times, re-locking each time → `loss_cnt` goes 1,2,3,3. `pll_rst` pulses 4 cycles each time.
- **Timeout**: hold `locked`=0 → macro defined: `pll_rst` re-pulses every 36 cycles and `fault`=0. Macro undefined: `state`=4, `fault`=1, `pll_rst`=1 after 32 WAIT_LOCK cycles.
- **Manual retry and async reset**: in FAULT, pulse `sw_rst_req` → next cycle `state`=0, `fault`=0. Assert `rst_n` in mid-STABLE → all outputs return to reset values immediately.
